// File: rtl/uart_tx_scheduler_if.sv
// Bundle of keyboard, host and transmitter signals for the UART TX scheduler.
// The slave modport is the scheduler itself; the master modport is whatever
// surrounds it (keyboard source, terminal host, UART transmitter).
//
// Handshake semantics:
//   kbd_valid  : one-cycle push pulse, no backpressure; bytes arriving when
//                the queue is full (and nothing leaves that cycle) are dropped.
//   host_valid : held with host_data stable until a cycle where host_valid and
//                host_ready are both 1; that rising edge is the transfer.
//   tx_start   : one-cycle pulse; tx_data stays stable until tx_busy has
//                risen and fallen again (or the busy wait times out).
interface uart_tx_scheduler_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          kbd_valid;
  logic [7:0]    kbd_data;
  logic          host_valid;
  logic [7:0]    host_data;
  logic          host_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          kbd_overflow;
  logic          tx_timeout;
  logic [CW-1:0] fifo_count;
  logic [1:0]    state;

  modport slave (
    input  kbd_valid, kbd_data, host_valid, host_data, tx_busy,
    output host_ready, tx_start, tx_data, kbd_overflow, tx_timeout,
           fifo_count, state
  );

  modport master (
    output kbd_valid, kbd_data, host_valid, host_data, tx_busy,
    input  host_ready, tx_start, tx_data, kbd_overflow, tx_timeout,
           fifo_count, state
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART TX scheduler: merges a buffered keyboard byte stream and a held
// host (terminal response) byte stream onto one UART transmitter, with
// round-robin arbitration, a busy-rise watchdog and sticky error flags.
// The FSM state is exported on bus.state (IDLE=0, LOAD=1, WAIT_BUSY=2,
// WAIT_DONE=3).
module uart_tx_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_scheduler_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;

  // Keyboard FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // 1 when the keyboard was granted last; reset value 0 lets keyboard win
  // the first tie.
  logic          last_kbd_q;

  logic [7:0]    tx_data_q;
  logic          tx_start_q;
  logic          overflow_q;
  logic          timeout_q;
  logic [TW-1:0] tmo_cnt_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic          kbd_req;
  logic          host_req;
  logic          grant_kbd;
  logic          grant_host;
  logic          timeout_hit;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign kbd_req    = !fifo_empty;
  assign host_req   = bus.host_valid;

  // Reset blocks both the push and the host handshake.
  assign push    = bus.kbd_valid && !rst;
  assign pop     = grant_kbd && !rst;
  // A push onto a full queue still fits when the head leaves the same cycle.
  assign push_ok = push && (!fifo_full || pop);
  assign drop    = push && fifo_full && !pop;

  // Next-state, grant and watchdog decisions
  always_comb begin
    state_d     = state_q;
    grant_kbd   = 1'b0;
    grant_host  = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        // Nothing is handed over while the transmitter still reports busy.
        if (!bus.tx_busy) begin
          if (kbd_req && (!host_req || !last_kbd_q)) begin
            grant_kbd = 1'b1;
          end else if (host_req) begin
            grant_host = 1'b1;
          end
          if (grant_kbd || grant_host) begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT_DONE: begin
        // Returning to IDLE is the whole action; the next grant is made
        // from IDLE one cycle later at the earliest.
        if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage write (contents need no reset; occupancy is tracked below)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= bus.kbd_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmit byte, start pulse and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      last_kbd_q <= 1'b0;
    end else begin
      // The pulse is high exactly during the LOAD cycle.
      tx_start_q <= (state_d == LOAD);
      if (grant_kbd) begin
        tx_data_q  <= mem[rd_ptr_q];
        last_kbd_q <= 1'b1;
      end else if (grant_host) begin
        tx_data_q  <= bus.host_data;
        last_kbd_q <= 1'b0;
      end
    end
  end

  // Busy-rise watchdog counter and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        tmo_cnt_q <= '0;
      end else if (state_q == WAIT_BUSY && !bus.tx_busy && !timeout_hit) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.host_ready   = grant_host && !rst;
  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.kbd_overflow = overflow_q;
  assign bus.tx_timeout   = timeout_q;
  assign bus.fifo_count   = count_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a simple transmitter busy model,
// a start monitor scoring transmitted bytes against an expected queue, and
// a linear sequence of directed steps.
module tb_uart_tx_scheduler;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.FIFO_DEPTH(DEPTH)) ifc ();

  uart_tx_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int total     = 0;
  int bad       = 0;
  int start_cnt = 0;
  int busy_mode = 0;  // 0: normal frame model, 1: stuck high, 2: stuck low
  int busy_cnt  = 0;
  int base;
  logic [7:0] exp_q[$];

  // Transmitter model: busy rises the cycle after tx_start and lasts 10 cycles
  always @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 0;
    end else if (ifc.tx_start === 1'b1) begin
      busy_cnt <= 10;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  assign ifc.tx_busy = (busy_mode == 1) || (busy_mode == 0 && busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start monitor: every tx_start must carry the next expected byte
  always @(negedge clk) begin
    if (ifc.tx_start === 1'b1) begin
      start_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL tx_unexpected observed=0x%0h expected=none", ifc.tx_data);
      end
      if (exp_q.size() != 0) check("tx_byte", ifc.tx_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.kbd_valid  = 1'b0;
    ifc.host_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (!(start_cnt == target && ifc.state == 2'd0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_starts"}, start_cnt, target);
    check({tag, "_idle"}, ifc.state, 0);
  endtask

  initial begin
    ifc.kbd_valid  = 1'b0;
    ifc.kbd_data   = 8'h00;
    ifc.host_valid = 1'b0;
    ifc.host_data  = 8'h00;
    busy_mode      = 0;
    rst            = 1'b1;

    // Reset with activity on every input: everything must be ignored
    step();
    ifc.kbd_valid  = 1'b1;
    ifc.kbd_data   = 8'h99;
    ifc.host_valid = 1'b1;
    ifc.host_data  = 8'h98;
    #1;
    check("rst_host_ready", ifc.host_ready, 0);
    step();
    check("rst_state", ifc.state, 0);
    check("rst_count", ifc.fifo_count, 0);
    check("rst_tx_start", ifc.tx_start, 0);
    check("rst_tx_data", ifc.tx_data, 0);
    check("rst_overflow", ifc.kbd_overflow, 0);
    check("rst_timeout", ifc.tx_timeout, 0);
    check("rst_host_ready2", ifc.host_ready, 0);
    ifc.kbd_valid  = 1'b0;
    ifc.host_valid = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst_count", ifc.fifo_count, 0);
    check("post_rst_starts", start_cnt, 0);

    // Single key: start two cycles after the push
    base = start_cnt;
    exp_q.push_back(8'h41);
    ifc.kbd_valid = 1'b1;
    ifc.kbd_data  = 8'h41;
    step();
    ifc.kbd_valid = 1'b0;
    check("key_n1_count", ifc.fifo_count, 1);
    check("key_n1_start", ifc.tx_start, 0);
    check("key_n1_state", ifc.state, 0);
    step();
    check("key_n2_start", ifc.tx_start, 1);
    check("key_n2_data", ifc.tx_data, 8'h41);
    check("key_n2_state", ifc.state, 1);
    check("key_n2_count", ifc.fifo_count, 0);
    step();
    check("key_n3_start", ifc.tx_start, 0);
    check("key_n3_state", ifc.state, 2);
    wait_done("key", base + 1, 40);
    check("key_data_hold", ifc.tx_data, 8'h41);

    // Host byte: start the cycle after the handshake
    base = start_cnt;
    exp_q.push_back(8'h55);
    ifc.host_valid = 1'b1;
    ifc.host_data  = 8'h55;
    #1;
    check("host_ready", ifc.host_ready, 1);
    step();
    ifc.host_valid = 1'b0;
    check("host_start", ifc.tx_start, 1);
    check("host_data", ifc.tx_data, 8'h55);
    wait_done("host", base + 1, 40);

    // Contention from reset: keyboard wins the first tie, then alternate
    busy_mode = 1;
    do_reset();
    base = start_cnt;
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h62);
    ifc.kbd_valid = 1'b1;
    ifc.kbd_data  = 8'h61;
    step();
    ifc.kbd_data  = 8'h62;
    step();
    ifc.kbd_valid  = 1'b0;
    ifc.host_valid = 1'b1;
    ifc.host_data  = 8'h1B;
    #1;
    check("cont_count", ifc.fifo_count, 2);
    check("cont_busy_block", ifc.host_ready, 0);
    busy_mode = 0;
    #1;
    check("cont_tie_kbd", ifc.host_ready, 0);
    step();
    check("cont_first_start", ifc.tx_start, 1);
    check("cont_first_data", ifc.tx_data, 8'h61);
    begin
      int n = 0;
      while (ifc.host_ready !== 1'b1 && n < 100) begin
        step();
        n++;
      end
    end
    check("cont_host_accept", ifc.host_ready, 1);
    step();
    ifc.host_valid = 1'b0;
    check("cont_host_data", ifc.tx_data, 8'h1B);
    wait_done("cont", base + 3, 200);

    // Overflow: fifth key dropped while transmitter is stuck busy
    base = start_cnt;
    busy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      ifc.kbd_valid = 1'b1;
      ifc.kbd_data  = 8'(8'h30 + i);
      exp_q.push_back(8'(8'h30 + i));
      step();
    end
    check("ovf_full_count", ifc.fifo_count, 4);
    check("ovf_not_yet", ifc.kbd_overflow, 0);
    ifc.kbd_data = 8'h34;
    step();
    ifc.kbd_valid = 1'b0;
    check("ovf_count", ifc.fifo_count, 4);
    check("ovf_flag", ifc.kbd_overflow, 1);
    busy_mode = 0;
    wait_done("ovf", base + 4, 300);
    check("ovf_drained", ifc.fifo_count, 0);
    check("ovf_sticky", ifc.kbd_overflow, 1);

    // Full FIFO with push in the grant cycle: accepted, no overflow
    busy_mode = 1;
    do_reset();
    check("pp_ovf_cleared", ifc.kbd_overflow, 0);
    base = start_cnt;
    for (int i = 0; i < 4; i++) begin
      ifc.kbd_valid = 1'b1;
      ifc.kbd_data  = 8'(8'h70 + i);
      exp_q.push_back(8'(8'h70 + i));
      step();
    end
    exp_q.push_back(8'h74);
    ifc.kbd_valid = 1'b0;
    #1;
    check("pp_full", ifc.fifo_count, 4);
    busy_mode = 0;
    ifc.kbd_valid = 1'b1;
    ifc.kbd_data  = 8'h74;
    step();
    ifc.kbd_valid = 1'b0;
    check("pp_count", ifc.fifo_count, 4);
    check("pp_overflow", ifc.kbd_overflow, 0);
    check("pp_start", ifc.tx_start, 1);
    check("pp_data", ifc.tx_data, 8'h70);
    wait_done("pp", base + 5, 400);

    // Busy never rises: watchdog fires TMO cycles after WAIT_BUSY entry
    base = start_cnt;
    busy_mode = 2;
    exp_q.push_back(8'h42);
    ifc.kbd_valid = 1'b1;
    ifc.kbd_data  = 8'h42;
    step();
    ifc.kbd_valid = 1'b0;
    step();
    check("tmo_start", ifc.tx_start, 1);
    step();
    check("tmo_entry_state", ifc.state, 2);
    check("tmo_entry_flag", ifc.tx_timeout, 0);
    repeat (TMO - 1) step();
    check("tmo_before_state", ifc.state, 2);
    check("tmo_before_flag", ifc.tx_timeout, 0);
    step();
    check("tmo_flag", ifc.tx_timeout, 1);
    check("tmo_state", ifc.state, 0);
    busy_mode = 0;
    exp_q.push_back(8'h43);
    ifc.kbd_valid = 1'b1;
    ifc.kbd_data  = 8'h43;
    step();
    ifc.kbd_valid = 1'b0;
    wait_done("tmo_next", base + 2, 60);
    check("tmo_sticky", ifc.tx_timeout, 1);

    // Reset during WAIT_DONE with three keys queued
    base = start_cnt;
    exp_q.push_back(8'h50);
    for (int i = 0; i < 4; i++) begin
      ifc.kbd_valid = 1'b1;
      ifc.kbd_data  = 8'(8'h50 + i);
      step();
    end
    ifc.kbd_valid = 1'b0;
    check("mid_state", ifc.state, 3);
    check("mid_count", ifc.fifo_count, 3);
    check("mid_starts", start_cnt, base + 1);
    rst = 1'b1;
    step();
    check("mid_rst_state", ifc.state, 0);
    check("mid_rst_count", ifc.fifo_count, 0);
    check("mid_rst_start", ifc.tx_start, 0);
    check("mid_rst_data", ifc.tx_data, 0);
    check("mid_rst_overflow", ifc.kbd_overflow, 0);
    check("mid_rst_timeout", ifc.tx_timeout, 0);
    check("mid_rst_host_ready", ifc.host_ready, 0);
    rst = 1'b0;
    repeat (30) step();
    check("mid_no_more_starts", start_cnt, base + 1);
    check("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, keyboard FIFO entries; power of two, 2..16.
REQ-002 Parameter BUSY_TIMEOUT, default 16, max cycles LOAD->WAIT_BUSY may wait for tx_busy rise.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 kbd_valid  input  1  one-cycle pulse: kbd_data valid (keyboard ASCII source, no backpressure).
REQ-006 kbd_data  input  8  keyboard ASCII byte.
REQ-007 host_valid  input  1  terminal-response byte pending; held until accepted.
REQ-008 host_data  input  8  terminal-response byte; stable while host_valid=1.
REQ-009 host_ready  output  1  combinational; host transfer when host_valid and host_ready both 1.
REQ-010 tx_start  output  1  registered one-cycle start pulse to UART transmitter.
REQ-011 tx_data  output  8  registered byte to transmitter; stable from tx_start until return to IDLE.
REQ-012 tx_busy  input  1  transmitter busy.
REQ-013 kbd_overflow  output  1  sticky: keyboard byte dropped.
REQ-014 tx_timeout  output  1  sticky: tx_busy did not rise within BUSY_TIMEOUT.
REQ-015 fifo_count  output  clog2(FIFO_DEPTH)+1  keyboard FIFO occupancy.

Function
REQ-016 Keyboard FIFO: kbd_valid=1 writes kbd_data at tail; pop at head when arbiter grants keyboard.
REQ-017 Push and pop in same cycle both take effect; count unchanged; push onto full FIFO with simultaneous pop accepted.
REQ-018 Push onto full FIFO without pop: byte dropped, FIFO unchanged, kbd_overflow set to 1.
REQ-019 Pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH nor underflows.
REQ-020 States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: no grant while tx_busy=1; else keyboard requests when FIFO non-empty, host when host_valid=1.
REQ-022 Arbitration round-robin: both requesting -> grant the one not granted last; single requester always granted.
REQ-023 host_ready=1 only in IDLE, tx_busy=0, host granted; all other cycles 0.
REQ-024 On grant: load granted byte into tx_data (keyboard: pop head), update last-grant, go LOAD.
REQ-025 LOAD: tx_start=1 this cycle only; go WAIT_BUSY, clear timeout counter.
REQ-026 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; counter reaching BUSY_TIMEOUT -> set tx_timeout, go IDLE.
REQ-027 WAIT_DONE: tx_busy=0 -> IDLE; no new grant that same cycle (IDLE grants next cycle earliest).
REQ-028 Latency: kbd_valid in cycle N, FIFO empty, IDLE, tx_busy=0 -> tx_start high in cycle N+2.
REQ-029 Latency: host handshake in cycle N -> tx_start high in cycle N+1 with tx_data=host_data.
REQ-030 Exactly one tx_start per accepted byte; bytes from each requester transmitted in acceptance order.
REQ-031 kbd_valid accepted in every state, including during transmission.

Reset
REQ-032 rst=1 at a rising edge: state IDLE, FIFO empty, fifo_count=0, tx_start=0, tx_data=0, kbd_overflow=0, tx_timeout=0, last-grant=host (keyboard wins first tie).
REQ-033 Reset mid-transmission discards in-flight and queued bytes; no tx_start while rst=1.
REQ-034 kbd_valid and host handshake ignored while rst=1; host_ready=0 during rst.

Verification
REQ-035 Single key: kbd_valid with 0x41, tx_busy model rises 1 cycle after start, lasts 10 cycles -> one tx_start 2 cycles later, tx_data=0x41, IDLE after busy falls.
REQ-036 Contention: FIFO holds 0x61,0x62, host_valid=1 with 0x1B from reset -> transmit order 0x61, 0x1B, 0x62.
REQ-037 Overflow: 5 kbd_valid pulses (0x30..0x34) while tx_busy=1 stuck, FIFO_DEPTH=4 -> fifo_count=4, kbd_overflow=1, 0x34 lost; after release 0x30..0x33 sent in order.
REQ-038 Timeout: tx_busy held 0 after tx_start -> tx_timeout=1 exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry, state IDLE, next byte still served.
REQ-039 Full push+pop: FIFO full, kbd_valid in grant cycle -> byte accepted, fifo_count stays 4, kbd_overflow=0.
REQ-040 Reset mid-frame: rst in WAIT_DONE with 3 bytes queued -> all outputs at reset values next cycle, no further tx_start.
